// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the iterative multiply/divide unit.
//   state_t           : FSM states IDLE / RUN / WB
//   OP_MUL / OP_DIV   : encoding of the op input
//   DEFAULT_WIDTH     : default operand/result width
//   DEFAULT_SEL_W     : default register select width
// The divider is only compiled in when MDU_DIV_EN is defined.
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SEL_W = 4;

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if -- request / write-back bus of the multiply/divide unit.
//   Request  (master -> slave): start, op, aIn, bIn, dstSel
//   Response (slave -> master): busy, done, wrEn, wrSel, wrData, hiOut, divZero
// master : the requester (register file / control)
// slave  : the mul_div_unit itself
interface mul_div_unit_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEL_W = DEFAULT_SEL_W
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] aIn;
  logic [WIDTH-1:0] bIn;
  logic [SEL_W-1:0] dstSel;
  logic             busy;
  logic             done;
  logic             wrEn;
  logic [SEL_W-1:0] wrSel;
  logic [WIDTH-1:0] wrData;
  logic [WIDTH-1:0] hiOut;
  logic             divZero;

  modport master (
    output start, op, aIn, bIn, dstSel,
    input  busy, done, wrEn, wrSel, wrData, hiOut, divZero
  );

  modport slave (
    input  start, op, aIn, bIn, dstSel,
    output busy, done, wrEn, wrSel, wrData, hiOut, divZero
  );

endinterface

// File: rtl/mdu_step.sv
// mdu_step -- one combinational iteration of the multiply/divide datapath.
// Ports:
//   op       : OP_MUL / OP_DIV (present only when MDU_DIV_EN is defined)
//   hi, lo   : current partial result (product halves, or remainder/quotient)
//   b        : multiplicand or divisor
//   hi_next, lo_next : partial result after this iteration
// Multiply: unsigned shift-and-add; lo holds the remaining multiplier bits.
// Divide (MDU_DIV_EN): restoring shift-subtract; hi is the partial
// remainder, lo shifts the dividend out and the quotient bits in.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
`ifdef MDU_DIV_EN
  input  logic             op,
`endif
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;
`ifdef MDU_DIV_EN
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
`endif

  always_comb begin
    // Add the multiplicand when the current multiplier bit is set, then
    // shift the (carry, hi, lo) chain right by one.
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
    hi_next = sum[WIDTH:1];
    lo_next = {sum[0], lo[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    shifted = {hi, lo[WIDTH-1]};
    // One extra bit so the borrow is visible in the MSB.
    diff    = {1'b0, shifted} - {2'b00, b};
    if (op == OP_DIV) begin
      if (!diff[WIDTH+1]) begin
        hi_next = diff[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative unsigned multiplier (and optional divider) with
// register-file write-back.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, aborts any operation in flight
//   bus  : mul_div_unit_if.slave -- start/op/aIn/bIn/dstSel request and
//          busy/done/wrEn/wrSel/wrData/hiOut/divZero response
// Macro MDU_DIV_EN compiles in the divider; without it op is ignored, every
// operation is a multiply and divZero is constant 0.
// Flow: IDLE latches the request, RUN does WIDTH iterations plus one cycle to
// load the result registers, WB presents the write for exactly one cycle.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEL_W = DEFAULT_SEL_W
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);

  localparam int             CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] b_reg;
  logic [SEL_W-1:0] sel_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             wr_en_reg;
  logic [SEL_W-1:0] wr_sel_reg;
  logic [WIDTH-1:0] wr_data_reg;
  logic [WIDTH-1:0] hi_out_reg;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
`ifdef MDU_DIV_EN
  logic             op_reg;
  logic             div_zero_reg;
  logic             div_by_zero;

  assign div_by_zero = (op_reg == OP_DIV) && (b_reg == '0);
`endif

  mdu_step #(.WIDTH(WIDTH)) u_step (
`ifdef MDU_DIV_EN
    .op      (op_reg),
`endif
    .hi      (hi_reg),
    .lo      (lo_reg),
    .b       (b_reg),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      b_reg       <= '0;
      sel_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      wr_en_reg   <= 1'b0;
      wr_sel_reg  <= '0;
      wr_data_reg <= '0;
      hi_out_reg  <= '0;
`ifdef MDU_DIV_EN
      op_reg       <= OP_MUL;
      div_zero_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            hi_reg    <= '0;
            lo_reg    <= bus.aIn;
            b_reg     <= bus.bIn;
            sel_reg   <= bus.dstSel;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
`ifdef MDU_DIV_EN
            op_reg    <= bus.op;
`endif
          end
        end

        RUN: begin
`ifdef MDU_DIV_EN
          if (div_by_zero) begin
            // Zero divisor: no iterations, all-ones quotient, dividend
            // (still untouched in lo_reg) as remainder.
            state_reg    <= WB;
            done_reg     <= 1'b1;
            wr_en_reg    <= 1'b1;
            wr_sel_reg   <= sel_reg;
            wr_data_reg  <= '1;
            hi_out_reg   <= lo_reg;
            div_zero_reg <= 1'b1;
          end else
`endif
          if (cnt_reg == CNT_LAST) begin
            state_reg   <= WB;
            done_reg    <= 1'b1;
            wr_en_reg   <= 1'b1;
            wr_sel_reg  <= sel_reg;
            wr_data_reg <= lo_reg;
            hi_out_reg  <= hi_reg;
`ifdef MDU_DIV_EN
            div_zero_reg <= 1'b0;
`endif
          end else begin
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        WB: begin
          // hiOut and divZero intentionally hold until the next WB.
          state_reg   <= IDLE;
          busy_reg    <= 1'b0;
          done_reg    <= 1'b0;
          wr_en_reg   <= 1'b0;
          wr_sel_reg  <= '0;
          wr_data_reg <= '0;
        end

        default: begin
          state_reg   <= IDLE;
          busy_reg    <= 1'b0;
          done_reg    <= 1'b0;
          wr_en_reg   <= 1'b0;
          wr_sel_reg  <= '0;
          wr_data_reg <= '0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.wrEn   = wr_en_reg;
  assign bus.wrSel  = wr_sel_reg;
  assign bus.wrData = wr_data_reg;
  assign bus.hiOut  = hi_out_reg;
`ifdef MDU_DIV_EN
  assign bus.divZero = div_zero_reg;
`else
  assign bus.divZero = 1'b0;
`endif

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the data width of operands and results.
REQ-002 The block SHALL have parameter SEL_W, default 4, the register select width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Ports SHALL be:
  clk  input  1  clock, all state updated on rising edge
  rst  input  1  synchronous active-high reset
  start  input  1  request a new operation
  op  input  1  0 = multiply, 1 = divide
  aIn  input  WIDTH  operand A (register file bus A)
  bIn  input  WIDTH  operand B (register file bus B)
  dstSel  input  SEL_W  destination register for the result
  busy  output  1  operation in progress
  done  output  1  one-cycle completion pulse
  wrEn  output  1  register file write enable
  wrSel  output  SEL_W  register file write select
  wrData  output  WIDTH  register file write data
  hiOut  output  WIDTH  product high half / remainder
  divZero  output  1  last divide had zero divisor

Function
REQ-005 The FSM SHALL have three states: IDLE, RUN, WB.
REQ-006 In IDLE, start=1 SHALL latch aIn, bIn, op and dstSel, clear the iteration counter, and move to RUN; busy SHALL be 1 from the next cycle.
REQ-007 start SHALL be ignored in RUN and WB, with no change to the latched operands.
REQ-008 RUN SHALL perform exactly WIDTH iterations, one per cycle.
  - Multiply: unsigned shift-and-add.
  - Divide: unsigned restoring shift-subtract.
REQ-009 After the last iteration, RUN SHALL move to WB, which SHALL last exactly one cycle and then return to IDLE.
REQ-010 In WB, wrEn and done SHALL be 1.
  - wrSel SHALL equal the latched dstSel.
  - wrData SHALL be the low WIDTH bits of the product, or the quotient.
REQ-011 Latency: start sampled at edge N SHALL give wrEn=1 in the cycle after edge N+WIDTH+1, i.e. 18 cycles for WIDTH=16.
REQ-012 hiOut SHALL be updated in WB with the product high half or the remainder.
  - It SHALL hold that value until the next WB.
REQ-013 busy SHALL be 1 in RUN and WB and 0 in IDLE.
REQ-014 Outside WB, wrEn and done SHALL be 0, and wrData and wrSel SHALL be 0.
REQ-015 Divide with divisor 0 SHALL skip RUN and go directly to WB on the next cycle.
  - quotient = all ones.
  - remainder = dividend.
  - divZero = 1.
REQ-016 divZero SHALL be updated in every WB: 1 only for a zero-divisor divide, otherwise 0.
REQ-017 Arithmetic SHALL be unsigned, and the full 2*WIDTH product SHALL be exact; there is no overflow flag.

Reset
REQ-018 rst SHALL force IDLE and set busy, done, wrEn, wrSel, wrData, hiOut and divZero to 0.
REQ-019 rst asserted in RUN or WB SHALL abort the operation, with no write-back on that or the following cycle.
REQ-020 rst SHALL take priority over a simultaneous start.

Configuration
REQ-021 Macro MDU_DIV_EN SHALL control the divider.
  - Defined: the divider and divZero logic SHALL be compiled in.
  - Undefined: op SHALL be ignored and every operation SHALL be a multiply; divZero SHALL be tied to 0 and no divide logic SHALL be synthesised.

Structure
REQ-022 Package mdu_pkg SHALL hold:
  - the FSM state enum typedef (IDLE, RUN, WB);
  - op encoding constants OP_MUL = 0 and OP_DIV = 1;
  - the default WIDTH and SEL_W constants.
REQ-023 One sub-module, mdu_step, SHALL implement a single combinational iteration: add/shift, or compare/subtract/shift under MDU_DIV_EN.
  - mul_div_unit SHALL hold all registers and the FSM.

Verification
REQ-024 Multiply 3*5, dstSel=7: wrEn=1 exactly 18 cycles after start, wrSel=7, wrData=0x000F, hiOut=0x0000, done pulse of one cycle.
REQ-025 Multiply 0xFFFF*0xFFFF: wrData=0x0001, hiOut=0xFFFE, divZero=0.
REQ-026 With MDU_DIV_EN, divide 100/7: wrData=0x000E, hiOut=0x0002; divide 0x1234/0: WB 2 cycles after start, wrData=0xFFFF, hiOut=0x1234, divZero=1.
REQ-027 start pulsed again 5 cycles into a multiply of 2*2 with aIn=9, bIn=9: result SHALL still be 0x0004, with exactly one wrEn pulse.
REQ-028 rst asserted 10 cycles into an operation: busy=0 next cycle, and no wrEn within 20 cycles; a new start afterwards SHALL complete normally.
REQ-029 Without MDU_DIV_EN, op=1 with 6 and 4: wrData=0x0018 (multiply), divZero=0.
